lamp_safety_driver: RTL and testbench

- Sits directly downstream of the four-way light sequencer. Consumes its 2-bit per-direction light codes and drives one-hot R/Y/G lamp outputs.
- Enforces two safety rules:
  - an all-red clearance interval whenever right-of-way moves to a different direction;
  - a latched flashing-red fail-safe on conflicting or illegal codes.
- The upstream sequencer gives no clearance itself. A direction change therefore costs CLEAR_CYCLES of that direction's green; this is accepted.

---
 rtl/lamp_safety_driver.sv | 162 ++++++++++++++++
 tb/tb_lamp_safety_driver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lamp_safety_driver.sv
// rtl/lamp_safety_driver.sv - lamp driver with all-red clearance and latched flashing-red fault
// Optional LAMP_FAULT_LOG_EN adds fault_count/fault_src outputs.
module lamp_safety_driver #(
   parameter int CLEAR_CYCLES = 2,
   parameter int FLASH_HALF   = 4,
   parameter int FAULT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] light_n,
   input  logic [1:0] light_e,
   input  logic [1:0] light_s,
   input  logic [1:0] light_w,
   input  logic       fault_clr,
   output logic [2:0] lamp_n,
   output logic [2:0] lamp_e,
   output logic [2:0] lamp_s,
   output logic [2:0] lamp_w,
   output logic       clearing,
   output logic       fault
`ifdef LAMP_FAULT_LOG_EN
   ,
   output logic [7:0] fault_count,
   output logic [3:0] fault_src
`endif
);

   localparam int CW = $clog2(CLEAR_CYCLES) + 1;
   localparam int FW = $clog2(FLASH_HALF) + 1;
   localparam int KW = $clog2(FAULT_CYCLES) + 1;

   localparam logic [1:0] S_PASS  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_FAULT = 2'd2;

   localparam logic [CW-1:0] CLEAR_INIT = CW'(CLEAR_CYCLES - 1);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
   localparam logic [KW-1:0] FAULT_MAX  = KW'(FAULT_CYCLES);
   localparam logic [11:0]   ALL_RED    = {4{3'b100}};

   function automatic logic [2:0] decode(input logic [1:0] code);
      case (code)
         2'b10:   decode = 3'b001;
         2'b01:   decode = 3'b010;
         default: decode = 3'b100;
      endcase
   endfunction

   logic [1:0]    state;
   logic [CW-1:0] clear_cnt;
   logic [FW-1:0] flash_cnt;
   logic          flash_on;
   logic [KW-1:0] conf_cnt;
   logic          last_valid;
   logic [1:0]    last_dir;
   logic [11:0]   lamps;

   logic [3:0]    active;
   logic          conflict;
   logic [1:0]    dir;
   logic [KW-1:0] conf_next;
   logic          trip;
   logic          flash_wrap;
   logic          flash_on_next;
   logic [11:0]   decoded;

   assign active   = {|light_n, |light_e, |light_s, |light_w};
   // Two or more active bits, or any illegal code.
   assign conflict = ((active & (active - 4'd1)) != 4'd0) ||
                     (&light_n) || (&light_e) || (&light_s) || (&light_w);
   assign conf_next = !conflict ? '0 :
                      (conf_cnt == FAULT_MAX) ? conf_cnt : conf_cnt + 1'b1;
   assign trip      = conflict && (conf_next == FAULT_MAX);
   assign decoded   = {decode(light_n), decode(light_e), decode(light_s), decode(light_w)};
   assign flash_wrap    = (flash_cnt == FLASH_LAST);
   assign flash_on_next = flash_wrap ? ~flash_on : flash_on;

   always_comb begin
      dir = 2'd3;
      if (active[3])      dir = 2'd0;
      else if (active[2]) dir = 2'd1;
      else if (active[1]) dir = 2'd2;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_PASS;
         clear_cnt  <= '0;
         flash_cnt  <= '0;
         flash_on   <= 1'b1;
         conf_cnt   <= '0;
         last_valid <= 1'b0;
         last_dir   <= 2'd0;
         lamps      <= ALL_RED;
         clearing   <= 1'b0;
         fault      <= 1'b0;
`ifdef LAMP_FAULT_LOG_EN
         fault_count <= 8'd0;
         fault_src   <= 4'd0;
`endif
      end else begin
         conf_cnt <= conf_next;
         if (state == S_FAULT) begin
            if (!conflict && fault_clr) begin
               state      <= S_CLEAR;
               clear_cnt  <= CLEAR_INIT;
               last_valid <= 1'b0;
               flash_cnt  <= '0;
               flash_on   <= 1'b1;
               lamps      <= ALL_RED;
               clearing   <= 1'b1;
               fault      <= 1'b0;
            end else begin
               flash_cnt <= flash_wrap ? '0 : flash_cnt + 1'b1;
               flash_on  <= flash_on_next;
               lamps     <= {4{flash_on_next, 2'b00}};
            end
         end else if (trip) begin
            state     <= S_FAULT;
            flash_cnt <= '0;
            flash_on  <= 1'b1;
            lamps     <= ALL_RED;
            clearing  <= 1'b0;
            fault     <= 1'b1;
`ifdef LAMP_FAULT_LOG_EN
            if (fault_count != 8'd255) fault_count <= fault_count + 8'd1;
            fault_src <= active;
`endif
         end else if (conflict) begin
            lamps <= ALL_RED;
         end else if (state == S_CLEAR) begin
            if (clear_cnt != '0) begin
               clear_cnt <= clear_cnt - 1'b1;
               lamps     <= ALL_RED;
            end else begin
               state      <= S_PASS;
               clearing   <= 1'b0;
               lamps      <= decoded;
               last_valid <= |active;
               if (|active) last_dir <= dir;
            end
         end else if (active == 4'd0) begin
            lamps <= ALL_RED;
         end else if (!last_valid || dir == last_dir) begin
            lamps      <= decoded;
            last_dir   <= dir;
            last_valid <= 1'b1;
         end else begin
            state     <= S_CLEAR;
            clear_cnt <= CLEAR_INIT;
            lamps     <= ALL_RED;
            clearing  <= 1'b1;
         end
      end
   end

   assign lamp_n = lamps[11:9];
   assign lamp_e = lamps[8:6];
   assign lamp_s = lamps[5:3];
   assign lamp_w = lamps[2:0];

endmodule

// File: tb/tb_lamp_safety_driver.sv
// tb/tb_lamp_safety_driver.sv - self-checking bench for lamp_safety_driver
// Directed plan steps followed by random code patterns against a behavioural model.
module tb_lamp_safety_driver;

   localparam int CLEAR_CYCLES = 2;
   localparam int FLASH_HALF   = 4;
   localparam int FAULT_CYCLES = 1;

   localparam int M_PASS  = 0;
   localparam int M_CLEAR = 1;
   localparam int M_FAULT = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] light_n = 2'b00, light_e = 2'b00, light_s = 2'b00, light_w = 2'b00;
   logic       fault_clr = 1'b0;
   logic [2:0] lamp_n, lamp_e, lamp_s, lamp_w;
   logic       clearing, fault;
`ifdef LAMP_FAULT_LOG_EN
   logic [7:0] fault_count;
   logic [3:0] fault_src;
`endif

   int tests = 0;
   int fails = 0;

   // reference model state
   int         mode;
   int         clear_left;
   int         age;
   int         run;
   bit         lv;
   int         ld;
   bit [11:0]  exp_lamps;
   bit         exp_clr;
   bit         exp_fault;
   int         fcount;
   bit [3:0]   fsrc;

   lamp_safety_driver #(
      .CLEAR_CYCLES(CLEAR_CYCLES),
      .FLASH_HALF(FLASH_HALF),
      .FAULT_CYCLES(FAULT_CYCLES)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .light_n(light_n),
      .light_e(light_e),
      .light_s(light_s),
      .light_w(light_w),
      .fault_clr(fault_clr),
      .lamp_n(lamp_n),
      .lamp_e(lamp_e),
      .lamp_s(lamp_s),
      .lamp_w(lamp_w),
      .clearing(clearing),
      .fault(fault)
`ifdef LAMP_FAULT_LOG_EN
      ,
      .fault_count(fault_count),
      .fault_src(fault_src)
`endif
   );

   always #5 clk = ~clk;

   function automatic bit [2:0] lamp_of(input int code);
      if (code == 2) return 3'b001;
      if (code == 1) return 3'b010;
      return 3'b100;
   endfunction

   task automatic model_reset();
      mode = M_PASS; clear_left = 0; age = 0; run = 0; lv = 0; ld = 0;
      exp_lamps = {4{3'b100}}; exp_clr = 0; exp_fault = 0; fcount = 0; fsrc = 4'd0;
   endtask

   task automatic model_step(input int cn, input int ce, input int cs, input int cw, input bit clr);
      int  codes[4];
      int  nact;
      int  idx;
      bit  ill;
      bit  conf;
      bit [11:0] shown;
      codes = '{cn, ce, cs, cw};
      nact = 0; idx = 0; ill = 0;
      for (int i = 0; i < 4; i++) begin
         if (codes[i] != 0) begin nact++; idx = i; end
         if (codes[i] == 3) ill = 1;
      end
      conf = (nact > 1) || ill;
      shown = {lamp_of(cn), lamp_of(ce), lamp_of(cs), lamp_of(cw)};
      run = conf ? run + 1 : 0;
      if (mode == M_FAULT) begin
         if (!conf && clr) begin
            mode = M_CLEAR; clear_left = CLEAR_CYCLES; lv = 0;
            exp_lamps = {4{3'b100}};
         end else begin
            age++;
            exp_lamps = (((age / FLASH_HALF) % 2) == 0) ? {4{3'b100}} : 12'd0;
         end
      end else if (conf && run >= FAULT_CYCLES) begin
         mode = M_FAULT; age = 0;
         exp_lamps = {4{3'b100}};
         if (fcount < 255) fcount++;
         fsrc = {cn != 0, ce != 0, cs != 0, cw != 0};
      end else if (conf) begin
         exp_lamps = {4{3'b100}};
      end else if (mode == M_CLEAR) begin
         clear_left--;
         if (clear_left == 0) begin
            mode = M_PASS;
            exp_lamps = shown;
            lv = (nact == 1);
            if (nact == 1) ld = idx;
         end else begin
            exp_lamps = {4{3'b100}};
         end
      end else if (nact == 0) begin
         exp_lamps = {4{3'b100}};
      end else if (!lv || idx == ld) begin
         exp_lamps = shown; lv = 1; ld = idx;
      end else begin
         mode = M_CLEAR; clear_left = CLEAR_CYCLES;
         exp_lamps = {4{3'b100}};
      end
      exp_clr   = (mode == M_CLEAR);
      exp_fault = (mode == M_FAULT);
   endtask

   task automatic check(input string tag);
      logic [13:0] obs;
      logic [13:0] expv;
      obs  = {lamp_n, lamp_e, lamp_s, lamp_w, clearing, fault};
      expv = {exp_lamps, exp_clr, exp_fault};
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b (lamps nesw,clearing,fault)", tag, obs, expv);
      end
`ifdef LAMP_FAULT_LOG_EN
      tests++;
      assert ({fault_count, fault_src} === {8'(fcount), fsrc}) else begin
         fails++;
         $error("FAIL %s_log observed=%0d/%b expected=%0d/%b", tag, fault_count, fault_src, fcount, fsrc);
      end
`endif
   endtask

   task automatic step(input int cn, input int ce, input int cs, input int cw, input bit clr,
                       input string tag);
      light_n = 2'(cn); light_e = 2'(ce); light_s = 2'(cs); light_w = 2'(cw);
      fault_clr = clr;
      @(posedge clk);
      model_step(cn, ce, cs, cw, clr);
      #1;
      check(tag);
   endtask

   initial begin
      int codes[4];
      int r, d1, d2, hold;
      model_reset();
      #12;
      check("reset");
      reset_n = 1'b1;
      #1;

      step(0, 0, 0, 0, 0, "idle");
      step(0, 0, 0, 0, 0, "idle2");
      step(2, 0, 0, 0, 0, "n_green");
      step(1, 0, 0, 0, 0, "n_yellow");
      step(0, 2, 0, 0, 0, "chg_clear1");
      step(0, 2, 0, 0, 0, "chg_clear2");
      step(0, 2, 0, 0, 0, "e_green");
      step(2, 2, 0, 0, 0, "conflict_fault");
      for (int i = 0; i < 9; i++) step(0, 2, 0, 0, 0, "flash");
      step(0, 0, 3, 0, 1, "clr_ignored");
      step(0, 0, 0, 2, 1, "clr_exit");
      step(0, 0, 0, 2, 0, "exit_clear2");
      step(0, 0, 0, 2, 0, "w_green");
      step(0, 2, 0, 0, 0, "rst_clear1");
      step(0, 2, 0, 0, 0, "rst_clear2");
      reset_n = 1'b0;
      #1;
      model_reset();
      check("async_rst");
      @(posedge clk);
      #1;
      check("rst_hold");
      reset_n = 1'b1;
      step(0, 2, 0, 0, 0, "post_rst_e");
      step(0, 1, 0, 0, 0, "post_rst_y");

      for (int k = 0; k < 60; k++) begin
         codes = '{0, 0, 0, 0};
         r = $urandom_range(0, 9);
         d1 = $urandom_range(0, 3);
         if (r < 6) begin
            codes[d1] = $urandom_range(1, 2);
         end else if (r < 8) begin
            d2 = (d1 + $urandom_range(1, 3)) % 4;
            codes[d1] = $urandom_range(1, 2);
            codes[d2] = $urandom_range(1, 2);
         end else if (r < 9) begin
            codes[d1] = 3;
         end
         hold = $urandom_range(1, 6);
         for (int h = 0; h < hold; h++)
            step(codes[0], codes[1], codes[2], codes[3], ($urandom_range(0, 3) == 0), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
